mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store engine that drives the byte-lane data memory (four 8-bit RAM lanes, 32-bit word, 4-bit byte write enable, synchronous read with one-cycle latency).
- Accepts one RISC-V load/store request at a time from the core pipeline and performs the access.
- Stores: generates byte enables and lane-replicated write data.
- Loads: waits out the RAM read latency, then extracts, aligns and sign/zero-extends the result.
- Reports misaligned or illegal accesses without touching memory.

Parameters:
ADDR_W, 32, width of core and memory address buses
ALIGN_CHECK, 1, 1 = misaligned halfword/word flagged as error; 0 = low address bits forced to alignment and no error

Ports:
clk_20M  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  request valid from core; sampled only when ready=1
we  input  1  1 = store, 0 = load
funct3  input  3  RV32I load/store funct3
addr_in  input  ADDR_W  byte address
wdata_in  input  32  store data (right-justified)
ready  output  1  unit idle, request may be accepted
done  output  1  one-cycle completion pulse
err  output  1  valid with done: misaligned or illegal funct3
rdata_out  output  32  load result, valid with done, held until next done
mem_addr  output  ADDR_W  memory byte address (word select uses bits [11:2])
mem_wdata  output  32  memory write data
mem_wren  output  4  per-byte write enables (bit n = byte lane n, bits [8n+7:8n])
mem_rdata  input  32  memory read data, valid the cycle after the address is sampled

Behaviour:
- Reset (async, immediate):
  - state=IDLE, ready=1, done=0, err=0.
  - rdata_out=0, mem_addr=0, mem_wdata=0, mem_wren=0.
  - Reset mid-operation abandons the access; mem_wren drops to 0 asynchronously.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE (ready=1):
  - req=0: stay in IDLE.
  - req=1 at an edge: latch addr_in, we, funct3 and wdata_in; compute byte enables and error.
  - Error detected: go to RESP with err=1 (memory never accessed).
  - Otherwise: go to ACCESS.
- ACCESS:
  - mem_addr = latched address.
  - Store: mem_wren = computed enables and mem_wdata = replicated data; next state RESP.
  - Load: mem_wren=0; next state WAIT.
- WAIT:
  - mem_rdata is valid this cycle.
  - At the edge, register the extracted result into rdata_out; next state RESP.
- RESP:
  - done=1 for exactly one cycle; err valid; ready=0.
  - Next state IDLE.
  - rdata_out is updated only by successful loads; it is unchanged by stores and errors.
- ready=1 only in IDLE. A req asserted while ready=0 is ignored and not queued; the core must hold req.
- Latency, counting cycles after the accept edge:
  - Store: done in the 2nd cycle.
  - Load: done in the 3rd cycle.
  - Error: done in the 1st cycle.
  - Back-to-back: a new req can be accepted in the cycle following done.
- Let bo = latched address bits [1:0].
- Store encoding:
  - SB (000): mem_wren = 4'b0001 << bo; mem_wdata = wdata_in[7:0] replicated ×4.
  - SH (001): mem_wren = 4'b0011 << bo (bo ∈ {0,2}); mem_wdata = wdata_in[15:0] replicated ×2.
  - SW (010): mem_wren = 4'b1111; mem_wdata = wdata_in.
  - Store funct3 011–111: illegal, err=1.
- Load extraction:
  - Byte = mem_rdata[8·bo+7 : 8·bo].
  - Halfword = mem_rdata[16·bo[1]+15 : 16·bo[1]].
  - LB (000) and LH (001) sign-extend to 32 bits; LBU (100) and LHU (101) zero-extend; LW (010) passes the word through.
  - Load funct3 011, 110, 111: illegal, err=1.
- Alignment (ALIGN_CHECK=1):
  - Halfword with bo[0]=1 → err.
  - Word with bo≠0 → err.
  - Byte accesses are never misaligned.
- Alignment (ALIGN_CHECK=0): offending low bits are cleared and the access proceeds with err=0.
- mem_wren is nonzero only in ACCESS for a store, so at most one write strobe cycle per request.

Test Plan:
- Reset: assert rst_n=0 mid-store while in ACCESS → mem_wren=0 immediately; after release ready=1, rdata_out=0, done=0.
- SW then LW: SW addr=0x100, data=0xDEADBEEF → mem_wren=1111 for one cycle, done in the 2nd cycle. Then LW 0x100 → done in the 3rd cycle with rdata_out=0xDEADBEEF, err=0.
- SB / LB / LBU: SB addr=0x103, data=0x00000080 → mem_wren=1000, mem_wdata=0x80808080. Then LB 0x103 → 0xFFFFFF80; LBU 0x103 → 0x00000080.
- SH / LH / LHU: SH addr=0x102, data=0x8001 → mem_wren=1100. Then LH 0x102 → 0xFFFF8001; LHU 0x102 → 0x00008001. The other bytes of word 0x100 are unchanged (LW → 0x8001BEEF).
- Errors: LW addr=0x101 → done in the 1st cycle, err=1, mem_wren never asserted, rdata_out unchanged. Likewise for SH addr=0x201 and for a load with funct3=011.
- Handshake: hold req=1 continuously with alternating SW/LW → each request is accepted exactly once, in the cycle after done; a req pulsed while ready=0 produces no access.

Source files
------------

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit
// Single-outstanding RV32I load/store engine in front of a four-lane byte RAM
// with a one-cycle synchronous read. A request is captured in IDLE, the memory
// is driven in ACCESS, read data is picked up in WAIT, and RESP pulses done.
// Illegal funct3 or misaligned accesses skip straight to RESP with err set and
// never strobe the memory.
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk_20M,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wren,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q;
  logic                legal;
  logic                misalign;

  // Per-lane write strobes for a given access size (00 byte, 01 half, 10 word)
  // at byte offset bo; bo is already aligned for the size when this is used.
  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] bo);
    case (size)
      2'b00:   return 4'b0001 << bo;
      2'b01:   return 4'b0011 << bo;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so any strobed lane sees the right byte.
  function automatic logic [31:0] replicate(input logic [1:0] size,
                                            input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Select the addressed byte/halfword from the RAM word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  bo,
                                               input logic [2:0]  f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{bo, 3'b000} +: 8];
    h = word[{bo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Decode the incoming request: legality, alignment, strobes and lane data.
  always_comb begin
    addr_d   = addr_in;
    legal    = 1'b0;
    misalign = 1'b0;
    case (funct3[1:0])
      2'b00: legal = we ? ~funct3[2] : 1'b1;
      2'b01: begin
        legal    = we ? ~funct3[2] : 1'b1;
        misalign = addr_in[0];
      end
      2'b10: begin
        legal    = ~funct3[2];
        misalign = |addr_in[1:0];
      end
      default: legal = 1'b0;
    endcase
    // Without alignment checking the offending low bits are simply dropped.
    if (!ALIGN_CHECK) begin
      if (funct3[1:0] == 2'b01) begin
        addr_d[0] = 1'b0;
      end else if (funct3[1:0] == 2'b10) begin
        addr_d[1:0] = 2'b00;
      end
      misalign = 1'b0;
    end
    err_d   = ~legal | misalign;
    be_d    = byte_enables(funct3[1:0], addr_d[1:0]);
    wdata_d = replicate(funct3[1:0], wdata_in);
  end

  // FSM state register; reset abandons any access in flight.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/strobe outputs; strobes exist only in ACCESS.
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    mem_wren = 4'b0000;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          state_d = err_d ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          mem_wren = be_q;
          state_d  = RESP;
        end else begin
          state_d  = WAIT;
        end
      end
      WAIT: state_d = RESP;
      RESP: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request attributes on the accept edge.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      be_q    <= 4'b0000;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (state_q == IDLE && req) begin
      addr_q  <= addr_d;
      we_q    <= we;
      f3_q    <= funct3;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Load result register: written only when read data is valid in WAIT.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
    end else if (state_q == WAIT) begin
      rdata_q <= load_extract(mem_rdata, addr_q[1:0], f3_q);
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// Bench for mem_access_unit: byte-lane RAM model plus a byte-addressed
// reference memory that predicts results from the RV32I load/store rules.
module tb_mem_access_unit;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk_20M = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr_in = 32'd0;
  logic [31:0] wdata_in = 32'd0;
  logic        ready, done, err;
  logic [31:0] rdata_out, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wren;

  logic [31:0] ram [0:1023];
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] last_rd = 32'd0;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;

  mem_access_unit #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) dut (
    .clk_20M(clk_20M), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3),
    .addr_in(addr_in), .wdata_in(wdata_in), .ready(ready), .done(done),
    .err(err), .rdata_out(rdata_out), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  always #25 clk_20M = ~clk_20M;

  // Byte-lane RAM with one-cycle synchronous read.
  always @(posedge clk_20M) begin
    for (int n = 0; n < 4; n++)
      if (mem_wren[n] === 1'b1) ram[mem_addr[11:2]][8*n +: 8] <= mem_wdata[8*n +: 8];
    mem_rdata <= ram[mem_addr[11:2]];
  end

  // Count accepted requests.
  always @(posedge clk_20M)
    if (rst_n === 1'b1 && ready === 1'b1 && req === 1'b1) acc_cnt <= acc_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: predicts latency, error, strobes, lane data and load result.
  task automatic model_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output int e_lat, output logic e_err,
                           output logic [3:0] e_wren, output logic [31:0] e_wdata,
                           output logic [31:0] e_rd);
    int n;
    bit legal;
    logic [31:0] v;
    case (f3[1:0])
      2'b00: n = 1;
      2'b01: n = 2;
      2'b10: n = 4;
      default: n = 0;
    endcase
    if (w) legal = (f3 == F_B) || (f3 == F_H) || (f3 == F_W);
    else   legal = (n != 0) && (f3 != 3'b110);
    e_err = 1'b1;
    if (legal) e_err = ((a % n) != 0);
    e_wren = 4'b0000;
    e_wdata = 32'd0;
    e_rd = last_rd;
    if (e_err) begin
      e_lat = 1;
    end else if (w) begin
      e_lat = 2;
      e_wren = 4'(((1 << n) - 1) << (a % 4));
      for (int k = 0; k < 4; k++) e_wdata[8*k +: 8] = d[8*(k % n) +: 8];
      for (int i = 0; i < n; i++) ref_mem[(a + i) % 4096] = d[8*i +: 8];
    end else begin
      e_lat = 3;
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) % 4096]) << (8*i));
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      last_rd = v;
      e_rd = v;
    end
  endtask

  // Drive one request and observe it until done (bounded); optionally pulse a
  // stray store request while the unit is busy.
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit glitch, output int lat,
                        output logic [3:0] wren_seen, output int wren_cycles,
                        output logic [31:0] wdata_seen, output logic [31:0] addr_seen,
                        output logic e, output logic [31:0] rd);
    int t;
    lat = -1; wren_seen = 4'b0000; wren_cycles = 0; wdata_seen = 32'd0;
    addr_seen = 32'd0; e = 1'b0; rd = 32'd0;
    t = 0;
    while (ready !== 1'b1 && t < 20) begin @(negedge clk_20M); t++; end
    if (ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL ready_timeout got=%b exp=1", ready);
      return;
    end
    req = 1'b1; we = w; funct3 = f3; addr_in = a; wdata_in = d;
    @(posedge clk_20M); #1 req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_20M);
      if (c == 1) addr_seen = mem_addr;
      if (mem_wren !== 4'b0000) begin
        wren_seen = mem_wren; wren_cycles++; wdata_seen = mem_wdata;
      end
      if (done === 1'b1) begin lat = c; e = err; rd = rdata_out; break; end
      if (glitch && c == 1) begin
        req = 1'b1; we = 1'b1; funct3 = F_W; addr_in = 32'h300; wdata_in = 32'hBAD0BAD0;
      end
      if (glitch && c == 2) req = 1'b0;
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    #5 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin failures++;
      $display("FAIL rst_ctrl got=%b%b%b exp=100", ready, done, err); end
    checks++; if (rdata_out !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_wren !== 0) begin
      failures++; $display("FAIL rst_data got=%h %h %h %b exp=0", rdata_out, mem_addr, mem_wdata, mem_wren); end
    repeat (2) @(negedge clk_20M);
    rst_n = 1'b1;
    @(negedge clk_20M);
    req = 1'b1; we = 1'b1; funct3 = F_W; addr_in = 32'h100; wdata_in = 32'h12345678;
    @(posedge clk_20M); #1 req = 1'b0;
    checks++; if (mem_wren !== 4'b1111) begin failures++;
      $display("FAIL rst_access_wren got=%b exp=1111", mem_wren); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_wren !== 4'b0000) begin failures++;
      $display("FAIL rst_async_wren got=%b exp=0000", mem_wren); end
    @(negedge clk_20M); rst_n = 1'b1;
    @(negedge clk_20M);
    checks++; if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || rdata_out !== 32'd0) begin
      failures++; $display("FAIL rst_release got=%b%b%b %h exp=100 0", ready, done, err, rdata_out); end
    last_rd = 32'd0;
  endtask

  task automatic test_sw_lw();
    int lat, wc, el; logic [3:0] ws, ew; logic [31:0] wd, as, rd, ed, er; logic e, ee;
    model_req(1'b1, F_W, 32'h100, 32'hDEADBEEF, el, ee, ew, ed, er);
    do_req(1'b1, F_W, 32'h100, 32'hDEADBEEF, 1'b0, lat, ws, wc, wd, as, e, rd);
    checks++; if (ws !== 4'b1111 || wc !== 1) begin failures++;
      $display("FAIL sw_wren got=%b x%0d exp=1111 x1", ws, wc); end
    checks++; if (lat !== 2 || e !== 1'b0) begin failures++;
      $display("FAIL sw_done got=lat%0d err%b exp=lat2 err0", lat, e); end
    model_req(1'b0, F_W, 32'h100, 32'd0, el, ee, ew, ed, er);
    do_req(1'b0, F_W, 32'h100, 32'd0, 1'b0, lat, ws, wc, wd, as, e, rd);
    checks++; if (lat !== 3 || e !== 1'b0 || wc !== 0) begin failures++;
      $display("FAIL lw_done got=lat%0d err%b wc%0d exp=lat3 err0 wc0", lat, e, wc); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++;
      $display("FAIL lw_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_byte();
    int lat, wc, el; logic [3:0] ws, ew; logic [31:0] wd, as, rd, ed, er; logic e, ee;
    model_req(1'b1, F_B, 32'h103, 32'h80, el, ee, ew, ed, er);
    do_req(1'b1, F_B, 32'h103, 32'h80, 1'b0, lat, ws, wc, wd, as, e, rd);
    checks++; if (ws !== 4'b1000 || wd !== 32'h80808080 || lat !== 2) begin failures++;
      $display("FAIL sb got=%b %h lat%0d exp=1000 80808080 lat2", ws, wd, lat); end
    model_req(1'b0, F_B, 32'h103, 32'd0, el, ee, ew, ed, er);
    do_req(1'b0, F_B, 32'h103, 32'd0, 1'b0, lat, ws, wc, wd, as, e, rd);
    checks++; if (rd !== 32'hFFFFFF80 || e !== 1'b0) begin failures++;
      $display("FAIL lb got=%h err%b exp=ffffff80 err0", rd, e); end
    model_req(1'b0, F_BU, 32'h103, 32'd0, el, ee, ew, ed, er);
    do_req(1'b0, F_BU, 32'h103, 32'd0, 1'b0, lat, ws, wc, wd, as, e, rd);
    checks++; if (rd !== 32'h00000080) begin failures++;
      $display("FAIL lbu got=%h exp=00000080", rd); end
  endtask

  task automatic test_half();
    int lat, wc, el; logic [3:0] ws, ew; logic [31:0] wd, as, rd, ed, er; logic e, ee;
    model_req(1'b1, F_H, 32'h102, 32'h8001, el, ee, ew, ed, er);
    do_req(1'b1, F_H, 32'h102, 32'h8001, 1'b0, lat, ws, wc, wd, as, e, rd);
    checks++; if (ws !== 4'b1100 || wd !== 32'h80018001) begin failures++;
      $display("FAIL sh got=%b %h exp=1100 80018001", ws, wd); end
    model_req(1'b0, F_H, 32'h102, 32'd0, el, ee, ew, ed, er);
    do_req(1'b0, F_H, 32'h102, 32'd0, 1'b0, lat, ws, wc, wd, as, e, rd);
    checks++; if (rd !== 32'hFFFF8001) begin failures++;
      $display("FAIL lh got=%h exp=ffff8001", rd); end
    model_req(1'b0, F_HU, 32'h102, 32'd0, el, ee, ew, ed, er);
    do_req(1'b0, F_HU, 32'h102, 32'd0, 1'b0, lat, ws, wc, wd, as, e, rd);
    checks++; if (rd !== 32'h00008001) begin failures++;
      $display("FAIL lhu got=%h exp=00008001", rd); end
    model_req(1'b0, F_W, 32'h100, 32'd0, el, ee, ew, ed, er);
    do_req(1'b0, F_W, 32'h100, 32'd0, 1'b0, lat, ws, wc, wd, as, e, rd);
    checks++; if (rd !== 32'h8001BEEF) begin failures++;
      $display("FAIL lw_merge got=%h exp=8001beef", rd); end
  endtask

  task automatic test_errors();
    int lat, wc, el; logic [3:0] ws, ew; logic [31:0] wd, as, rd, ed, er; logic e, ee;
    logic        tw [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  tf [3] = '{F_W, F_H, 3'b011};
    logic [31:0] ta [3] = '{32'h101, 32'h201, 32'h100};
    for (int i = 0; i < 3; i++) begin
      model_req(tw[i], tf[i], ta[i], 32'h5555AAAA, el, ee, ew, ed, er);
      do_req(tw[i], tf[i], ta[i], 32'h5555AAAA, 1'b0, lat, ws, wc, wd, as, e, rd);
      checks++; if (lat !== 1 || e !== 1'b1 || wc !== 0) begin failures++;
        $display("FAIL err_%0d got=lat%0d err%b wc%0d exp=lat1 err1 wc0", i, lat, e, wc); end
      checks++; if (rd !== 32'h8001BEEF) begin failures++;
        $display("FAIL err_rdata_%0d got=%h exp=8001beef", i, rd); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, wc, el, a0, got; logic [3:0] ws, ew; logic [31:0] wd, as, rd, ed, er; logic e, ee;
    a0 = acc_cnt;
    @(negedge clk_20M);
    for (int i = 0; i < 6; i++) begin
      req = 1'b1; we = (i % 2 == 0); funct3 = F_W;
      addr_in = 32'h500 + 32'(4 * (i / 2)); wdata_in = $urandom;
      model_req(we, funct3, addr_in, wdata_in, el, ee, ew, ed, er);
      got = 0;
      for (int c = 0; c < 12 && got == 0; c++) begin
        @(negedge clk_20M);
        if (done === 1'b1) got = c + 1;
      end
      checks++; if (got !== el) begin failures++;
        $display("FAIL b2b_lat_%0d got=%0d exp=%0d", i, got, el); end
      if (i % 2 == 1) begin
        checks++; if (rdata_out !== er || err !== 1'b0) begin failures++;
          $display("FAIL b2b_data_%0d got=%h err%b exp=%h err0", i, rdata_out, err, er); end
      end
      if (i == 5) req = 1'b0;
      @(negedge clk_20M);
      checks++; if (ready !== 1'b1) begin failures++;
        $display("FAIL b2b_ready_%0d got=%b exp=1", i, ready); end
    end
    repeat (3) @(negedge clk_20M);
    checks++; if (acc_cnt - a0 !== 6) begin failures++;
      $display("FAIL b2b_accepts got=%0d exp=6", acc_cnt - a0); end
    // Stray request while busy must be dropped.
    model_req(1'b0, F_W, 32'h300, 32'd0, el, ee, ew, ed, er);
    a0 = acc_cnt;
    do_req(1'b0, F_W, 32'h300, 32'd0, 1'b1, lat, ws, wc, wd, as, e, rd);
    checks++; if (lat !== 3 || wc !== 0 || rd !== er) begin failures++;
      $display("FAIL glitch_load got=lat%0d wc%0d %h exp=lat3 wc0 %h", lat, wc, rd, er); end
    got = 0;
    repeat (4) begin
      @(negedge clk_20M);
      if (done === 1'b1 || mem_wren !== 4'b0000) got++;
    end
    checks++; if (got !== 0 || acc_cnt - a0 !== 1) begin failures++;
      $display("FAIL glitch_ignored got=%0d extra cycles, %0d accepts exp=0, 1", got, acc_cnt - a0); end
    model_req(1'b0, F_W, 32'h300, 32'd0, el, ee, ew, ed, er);
    do_req(1'b0, F_W, 32'h300, 32'd0, 1'b0, lat, ws, wc, wd, as, e, rd);
    checks++; if (rd !== er) begin failures++;
      $display("FAIL glitch_mem got=%h exp=%h", rd, er); end
  endtask

  task automatic test_random();
    int lat, wc, el; logic [3:0] ws, ew; logic [31:0] wd, as, rd, ed, er, a, d;
    logic e, ee, w; logic [2:0] f3;
    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = 32'h400 + 32'($urandom_range(0, 31));
      d = $urandom;
      model_req(w, f3, a, d, el, ee, ew, ed, er);
      do_req(w, f3, a, d, 1'b0, lat, ws, wc, wd, as, e, rd);
      checks++; if (lat !== el || e !== ee) begin failures++;
        $display("FAIL rnd_done_%0d got=lat%0d err%b exp=lat%0d err%b", i, lat, e, el, ee); end
      checks++; if (ws !== ew || wc !== ((ew != 0) ? 1 : 0)) begin failures++;
        $display("FAIL rnd_wren_%0d got=%b x%0d exp=%b", i, ws, wc, ew); end
      if (ew != 4'b0000) begin
        checks++; if (wd !== ed) begin failures++;
          $display("FAIL rnd_wdata_%0d got=%h exp=%h", i, wd, ed); end
      end
      if (!ee) begin
        checks++; if (as !== a) begin failures++;
          $display("FAIL rnd_addr_%0d got=%h exp=%h", i, as, a); end
      end
      checks++; if (rd !== er) begin failures++;
        $display("FAIL rnd_rdata_%0d got=%h exp=%h", i, rd, er); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
